// File: rtl/aes_round_sb_sr_mc.sv
// Registered AES-128 encryption round slice: SubBytes -> ShiftRows -> MixColumns -> output register.
// Optional macro AES_FINAL_ROUND_EN adds the final_round input, which bypasses MixColumns.
module aes_round_sb_sr_mc (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] state_in,
`ifdef AES_FINAL_ROUND_EN
  input  logic         final_round,
`endif
  output logic         out_valid,
  output logic [127:0] state_out
);

  // Forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes a0..a3 sit from most to least significant
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [127:0] sub_bytes_s;
  logic [127:0] shift_rows_s;
  logic [127:0] mix_cols_s;
  logic [127:0] result_s;

  // Combinational round datapath: byte substitution, row rotation, column mix
  always_comb begin
    sub_bytes_s  = 128'h0;
    shift_rows_s = 128'h0;
    mix_cols_s   = 128'h0;
    for (int k = 0; k < 16; k++) begin
      sub_bytes_s[127-8*k -: 8] = sbox(state_in[127-8*k -: 8]);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        shift_rows_s[127-8*(r+4*c) -: 8] = sub_bytes_s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_cols_s[127-32*c -: 32] = mix_column(shift_rows_s[127-32*c -: 32]);
    end
  end

  // Select the value to register; the last round skips MixColumns
  always_comb begin
`ifdef AES_FINAL_ROUND_EN
    if (final_round) begin
      result_s = shift_rows_s;
    end else begin
      result_s = mix_cols_s;
    end
`else
    result_s = mix_cols_s;
`endif
  end

  // Output register; state_out holds across idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      state_out <= 128'h0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        state_out <= result_s;
      end else begin
        state_out <= state_out;
      end
    end
  end

endmodule

// File: tb/tb_aes_round_sb_sr_mc.sv
// Self-checking bench for aes_round_sb_sr_mc: directed FIPS-197 vectors, reset behaviour
// and randomized rounds compared with a GF(2^8) reference model built from first principles.
module tb_aes_round_sb_sr_mc;

  localparam logic [127:0] C1_IN = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C1_SB = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [127:0] C1_SR = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] C1_MC = 128'h5f72641557f5bc92f7be3b291db9f91a;
  localparam logic [127:0] ALL52 = {16{8'h52}};
  localparam logic [127:0] ALL63 = {16{8'h63}};
`ifdef AES_FINAL_ROUND_EN
  localparam logic FINAL_EN = 1'b1;
`else
  localparam logic FINAL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] state_in;
  logic         final_round;
  logic         out_valid;
  logic [127:0] state_out;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_state;
  logic         exp_valid;

  always #5 clk = ~clk;

  aes_round_sb_sr_mc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .state_in    (state_in),
`ifdef AES_FINAL_ROUND_EN
    .final_round (final_round),
`endif
    .out_valid   (out_valid),
    .state_out   (state_out)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] t;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      t = inv;
      s = inv;
      for (int i = 0; i < 4; i++) begin
        t = {t[6:0], t[7]};
        s = s ^ t;
      end
      sbox_tab[a] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] s, input logic fr);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) a[k] = sbox_tab[s[127-8*k -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r+4*c] = gmul(8'h02, b[r+4*c]) ^ gmul(8'h03, b[(r+1)%4+4*c]) ^
                   b[(r+2)%4+4*c] ^ b[(r+3)%4+4*c];
    o = 128'h0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = (fr && FINAL_EN) ? b[k] : m[k];
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, {127'h0, out_valid}, {127'h0, exp_valid});
    check_eq({tag, "_state"}, state_out, exp_state);
  endtask

  // One cycle: drive at the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic v, input logic [127:0] s, input logic fr, input string tag);
    @(negedge clk);
    in_valid    = v;
    state_in    = s;
    final_round = fr;
    @(posedge clk);
    #1;
    if (v) exp_state = model_round(s, final_round);
    exp_valid = v;
    check_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; state_in = 128'h0; final_round = 1'b0;
    exp_state = 128'h0; exp_valid = 1'b0;
    build_sbox();
    #2;
    check_eq("reset_valid", {127'h0, out_valid}, 128'h0);
    check_eq("reset_state", state_out, 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // C.1 round 1 with internal intermediates
    @(negedge clk);
    in_valid = 1'b1; state_in = C1_IN; final_round = 1'b0;
    #1;
    check_eq("c1_sub_bytes", dut.sub_bytes_s, C1_SB);
    check_eq("c1_shift_rows", dut.shift_rows_s, C1_SR);
    @(posedge clk);
    #1;
    exp_state = model_round(C1_IN, 1'b0); exp_valid = 1'b1;
    check_eq("c1_round", state_out, C1_MC);
    check_outputs("c1");

    // Streaming back-to-back, then idle hold
    step(1'b1, C1_IN, 1'b0, "stream0");
    check_eq("stream0_const", state_out, C1_MC);
    step(1'b1, 128'h0, 1'b0, "stream1");
    check_eq("stream1_const", state_out, ALL63);
    step(1'b1, ALL52, 1'b0, "stream2");
    check_eq("stream2_const", state_out, 128'h0);
    step(1'b1, 128'h0, 1'b0, "zeros");
    step(1'b0, ALL52, 1'b0, "idle");
    check_eq("idle_hold", state_out, ALL63);

`ifdef AES_FINAL_ROUND_EN
    step(1'b1, C1_IN, 1'b1, "final1");
    check_eq("final1_const", state_out, C1_SR);
    step(1'b1, C1_IN, 1'b0, "final0");
    check_eq("final0_const", state_out, C1_MC);
`endif

    // Asynchronous reset between edges while out_valid is high
    step(1'b1, C1_IN, 1'b0, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", {127'h0, out_valid}, 128'h0);
    check_eq("rst_async_state", state_out, 128'h0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_valid", {127'h0, out_valid}, 128'h0);
    check_eq("rst_hold_state", state_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    exp_state = 128'h0; exp_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_release");
    step(1'b1, ALL52, 1'b0, "first_after_reset");

    // Randomized rounds with random valid gaps
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
